// File: rtl/vec_alu_if.sv
// Bundles the operand, handshake and result signals of the vector ALU execute stage.
// The master side is the issuing pipeline and the slave side is the ALU.
interface vec_alu_if #(
    parameter int LANES = 16,
    parameter int WIDTH = 32
) ();
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [2:0]             op;
    logic                   vec_scalar;
    logic [LANES-1:0]       lane_mask;
    logic                   use_imm;
    logic [WIDTH-1:0]       imm;
    logic [LANES*WIDTH-1:0] src_a;
    logic [LANES*WIDTH-1:0] src_b;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*WIDTH-1:0] result;
    logic [3:0]             flags;
    logic                   busy;

    modport master (
        output flush, in_valid, op, vec_scalar, lane_mask, use_imm, imm, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, flags, busy
    );

    modport slave (
        input  flush, in_valid, op, vec_scalar, lane_mask, use_imm, imm, src_a, src_b, out_ready,
        output in_ready, out_valid, result, flags, busy
    );
endinterface

// File: rtl/vec_alu_pipe.sv
// Two-stage LANES x WIDTH vector ALU: S1 latches operands, S2 latches per-lane results and NZCV.
// Handshake: an op transfers on in_valid && in_ready; a result transfers on out_valid && out_ready.
module vec_alu_pipe #(
    parameter int LANES = 16,
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    vec_alu_if.slave bus
);
    typedef enum logic [2:0] {
        OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_ORR = 3'b011,
        OP_EOR = 3'b100, OP_MUL = 3'b101, OP_MOV = 3'b110, OP_ACC = 3'b111
    } op_e;

    logic                   r_s1_valid;
    logic                   r_s2_valid;
    op_e                    r_s1_op;
    logic [LANES-1:0]       r_s1_en;
    logic [WIDTH-1:0]       r_s1_a [LANES];
    logic [WIDTH-1:0]       r_s1_b [LANES];
    logic [WIDTH-1:0]       r_acc  [LANES];
    logic [LANES*WIDTH-1:0] r_result;
    logic [3:0]             r_flags;

    logic                   w_adv1, w_adv2, w_accept, w_xfer;
    logic [LANES-1:0]       w_en_in;
    logic [WIDTH-1:0]       w_lane_res [LANES];
    logic [WIDTH-1:0]       w_acc_next [LANES];
    logic [WIDTH:0]         w_wide;
    logic [WIDTH-1:0]       w_x, w_y, w_val;
    logic                   w_c, w_v;
    logic                   w_n_any, w_z_all, w_c_any, w_v_any;

    assign w_adv2   = !r_s2_valid || bus.out_ready;
    assign w_adv1   = !r_s1_valid || w_adv2;
    // Flush wins over a same-cycle accept, yet in_ready still reads 1 while flushing.
    assign w_accept = bus.in_valid && w_adv1 && !bus.flush;
    assign w_xfer   = r_s1_valid && w_adv2 && !bus.flush;
    assign w_en_in  = bus.vec_scalar ? bus.lane_mask : (LANES'(1) << (LANES - 1));

    assign bus.in_ready  = w_adv1 || bus.flush;
    assign bus.out_valid = r_s2_valid;
    assign bus.result    = r_result;
    assign bus.flags     = r_flags;
    assign bus.busy      = r_s1_valid || r_s2_valid;

    always_comb begin
        w_n_any = 1'b0;
        w_z_all = 1'b1;
        w_c_any = 1'b0;
        w_v_any = 1'b0;
        w_wide  = '0;
        w_x     = '0;
        w_y     = '0;
        w_val   = '0;
        w_c     = 1'b0;
        w_v     = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            w_acc_next[l] = r_acc[l];
            w_lane_res[l] = '0;
            // ACC reuses the adder with the accumulator as the first operand.
            w_x  = (r_s1_op == OP_ACC) ? r_acc[l]  : r_s1_a[l];
            w_y  = (r_s1_op == OP_ACC) ? r_s1_a[l] : r_s1_b[l];
            w_c  = 1'b0;
            w_v  = 1'b0;
            w_wide = {1'b0, w_x} + {1'b0, w_y};
            case (r_s1_op)
                OP_ADD, OP_ACC: begin
                    w_val = w_wide[WIDTH-1:0];
                    w_c   = w_wide[WIDTH];
                    w_v   = (w_x[WIDTH-1] == w_y[WIDTH-1]) && (w_val[WIDTH-1] != w_x[WIDTH-1]);
                end
                OP_SUB: begin
                    w_wide = {1'b0, w_x} - {1'b0, w_y};
                    w_val  = w_wide[WIDTH-1:0];
                    w_c    = !w_wide[WIDTH];
                    w_v    = (w_x[WIDTH-1] != w_y[WIDTH-1]) && (w_val[WIDTH-1] != w_x[WIDTH-1]);
                end
                OP_AND:  w_val = w_x & w_y;
                OP_ORR:  w_val = w_x | w_y;
                OP_EOR:  w_val = w_x ^ w_y;
                OP_MUL:  w_val = w_x * w_y;
                OP_MOV:  w_val = w_y;
                default: w_val = '0;
            endcase
            if (r_s1_en[l]) begin
                w_lane_res[l] = w_val;
                if (r_s1_op == OP_ACC) w_acc_next[l] = w_val;
                w_n_any = w_n_any | w_val[WIDTH-1];
                w_z_all = w_z_all & (w_val == '0);
                w_c_any = w_c_any | w_c;
                w_v_any = w_v_any | w_v;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s1_op    <= OP_ADD;
            r_s1_en    <= '0;
            r_result   <= '0;
            r_flags    <= '0;
            for (int l = 0; l < LANES; l++) begin
                r_s1_a[l] <= '0;
                r_s1_b[l] <= '0;
                r_acc[l]  <= '0;
            end
        end else begin
            if (bus.flush) begin
                r_s1_valid <= 1'b0;
                r_s2_valid <= 1'b0;
            end else begin
                if (w_adv1) r_s1_valid <= bus.in_valid;
                if (w_adv2) r_s2_valid <= r_s1_valid;
            end
            if (w_accept) begin
                r_s1_op <= op_e'(bus.op);
                r_s1_en <= w_en_in;
                for (int l = 0; l < LANES; l++) begin
                    r_s1_a[l] <= bus.src_a[l*WIDTH +: WIDTH];
                    r_s1_b[l] <= bus.use_imm ? bus.imm : bus.src_b[l*WIDTH +: WIDTH];
                end
            end
            // Accumulators commit on the S1->S2 move so back-to-back ACCs chain.
            if (w_xfer) begin
                r_flags <= {w_n_any, w_z_all, w_c_any, w_v_any};
                for (int l = 0; l < LANES; l++) begin
                    r_result[l*WIDTH +: WIDTH] <= w_lane_res[l];
                    r_acc[l]                   <= w_acc_next[l];
                end
            end
        end
    end
endmodule

// File: tb/tb_vec_alu_pipe.sv
// Scoreboard bench for vec_alu_pipe: directed scenarios then randomized ops with random back-pressure.
module tb_vec_alu_pipe;
  localparam int LANES = 16;
  localparam int WIDTH = 32;
  localparam int EW    = LANES * WIDTH + 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vec_alu_if #(.LANES(LANES), .WIDTH(WIDTH)) bus ();
  vec_alu_pipe #(.LANES(LANES), .WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int accepts = 0;
  bit rand_en = 1'b0;
  logic or_man = 1'b1;
  logic r_rand = 1'b1;
  logic [EW-1:0] exp_q[$];
  logic [WIDTH-1:0] ta[LANES];
  logic [WIDTH-1:0] tbv[LANES];
  logic [WIDTH-1:0] acc_m[LANES];

  assign bus.out_ready = rand_en ? r_rand : or_man;

  always @(posedge clk) begin
    #1;
    r_rand = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_w(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_v(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: returns {N,Z,C,V,result}; advances the model accumulators.
  function automatic logic [EW-1:0] model(input logic [2:0] op, input logic vec,
                                          input logic [LANES-1:0] mask, input logic use_imm,
                                          input logic [WIDTH-1:0] imm);
    logic [LANES*WIDTH-1:0] res = '0;
    logic [LANES-1:0] en = vec ? mask : {1'b1, {(LANES-1){1'b0}}};
    bit n = 1'b0, z = 1'b1, c = 1'b0, v = 1'b0;
    longint lim = longint'(1) << (WIDTH - 1);
    for (int l = 0; l < LANES; l++) begin
      logic [WIDTH-1:0] x, y, r;
      longint unsigned ux, uy, p;
      longint sx, sy, s;
      bit cc, vv;
      if (en[l]) begin
        x = (op == 3'd7) ? acc_m[l] : ta[l];
        y = (op == 3'd7) ? ta[l] : (use_imm ? imm : tbv[l]);
        ux = longint'(x);
        uy = longint'(y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        cc = 1'b0;
        vv = 1'b0;
        r = '0;
        case (op)
          3'd0, 3'd7: begin
            r = x + y;
            cc = ((ux + uy) >> WIDTH) != 0;
            s = sx + sy;
            vv = (s >= lim) || (s < -lim);
          end
          3'd1: begin
            r = x - y;
            cc = (ux >= uy);
            s = sx - sy;
            vv = (s >= lim) || (s < -lim);
          end
          3'd2: r = x & y;
          3'd3: r = x | y;
          3'd4: r = x ^ y;
          3'd5: begin
            p = ux * uy;
            r = p[WIDTH-1:0];
          end
          default: r = y;
        endcase
        if (op == 3'd7) acc_m[l] = r;
        n = n | r[WIDTH-1];
        z = z & (r == '0);
        c = c | cc;
        v = v | vv;
        res[l*WIDTH +: WIDTH] = r;
      end
    end
    return {n, z, c, v, res};
  endfunction

  task automatic send_op(input logic [2:0] op, input logic vec, input logic [LANES-1:0] mask,
                         input logic use_imm, input logic [WIDTH-1:0] imm);
    bus.op = op;
    bus.vec_scalar = vec;
    bus.lane_mask = mask;
    bus.use_imm = use_imm;
    bus.imm = imm;
    for (int l = 0; l < LANES; l++) begin
      bus.src_a[l*WIDTH +: WIDTH] = ta[l];
      bus.src_b[l*WIDTH +: WIDTH] = tbv[l];
    end
    bus.in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.in_ready && !bus.flush) begin
        exp_q.push_back(model(op, vec, mask, use_imm, imm));
        accepts++;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    errors++;
    $display("FAIL send_op: not accepted within 200 cycles");
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    or_man = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !bus.busy) return;
    end
    checks++;
    errors++;
    $display("FAIL drain: %0d results still pending", exp_q.size());
  endtask

  // Monitor: pops and compares on every output handshake, and checks stability while stalled.
  logic [EW-1:0] hold_v;
  bit hold_pending = 1'b0;
  always @(negedge clk) begin
    if (rst || bus.flush) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check_w("hold_valid", 64'(bus.out_valid), 64'd1);
        check_v("hold_data", {bus.flags, bus.result}, hold_v);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0h with empty expected queue", bus.flags);
        end else begin
          check_v("result", {bus.flags, bus.result}, exp_q.pop_front());
        end
      end
      hold_pending = bus.out_valid && !bus.out_ready;
      hold_v = {bus.flags, bus.result};
    end
  end

  initial begin
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.op = '0;
    bus.vec_scalar = 1'b0;
    bus.lane_mask = '0;
    bus.use_imm = 1'b0;
    bus.imm = '0;
    bus.src_a = '0;
    bus.src_b = '0;
    for (int l = 0; l < LANES; l++) begin
      ta[l] = '0;
      tbv[l] = '0;
      acc_m[l] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_w("reset_in_ready", 64'(bus.in_ready), 64'd1);
    check_w("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check_w("reset_busy", 64'(bus.busy), 64'd0);
    check_v("reset_result_flags", {bus.flags, bus.result}, '0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Scalar ADD overflow into the sign bit, with latency check.
    ta[15] = 32'h7FFF_FFFF;
    tbv[15] = 32'h1;
    send_op(3'd0, 1'b0, '0, 1'b0, '0);
    check_w("latency_edge1", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    check_w("latency_edge2", 64'(bus.out_valid), 64'd1);
    check_w("scalar_add_lane15", 64'(bus.result[15*WIDTH +: WIDTH]), 64'h8000_0000);
    check_w("scalar_add_flags", 64'(bus.flags), 64'h9);
    drain();

    // Vector SUB with partial mask, then with no lanes enabled.
    for (int l = 0; l < LANES; l++) begin
      ta[l] = 32'd5;
      tbv[l] = 32'd5;
    end
    send_op(3'd1, 1'b1, 16'h00FF, 1'b0, '0);
    send_op(3'd1, 1'b1, 16'h0000, 1'b0, '0);
    check_w("sub_mask_result", 64'(|bus.result), 64'd0);
    check_w("sub_mask_flags", 64'(bus.flags), 64'h6);
    @(posedge clk);
    #1;
    check_w("no_lane_flags", 64'(bus.flags), 64'h4);
    drain();

    // Back-pressure: four ops with the consumer stalled.
    or_man = 1'b0;
    accepts = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          for (int l = 0; l < LANES; l++) begin
            ta[l] = $urandom();
            tbv[l] = $urandom();
          end
          send_op(3'(i), 1'b1, 16'hFFFF, 1'b0, '0);
        end
      end
      begin
        repeat (4) @(posedge clk);
        #2;
        check_w("bp_accepts", 64'(accepts), 64'd2);
        check_w("bp_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        or_man = 1'b1;
      end
    join
    drain();

    // Back-to-back accumulation, then an idle flush keeps the accumulators.
    for (int l = 0; l < LANES; l++) ta[l] = 32'd3;
    repeat (3) send_op(3'd7, 1'b1, 16'hFFFF, 1'b0, '0);
    drain();
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check_w("idle_flush_busy", 64'(bus.busy), 64'd0);
    send_op(3'd7, 1'b1, 16'hFFFF, 1'b0, '0);
    @(posedge clk);
    #1;
    check_w("acc_after_flush", 64'(bus.result[0 +: WIDTH]), 64'd12);
    drain();

    // Flush with ops in flight, colliding with a new offer.
    or_man = 1'b0;
    for (int l = 0; l < LANES; l++) ta[l] = $urandom();
    send_op(3'd0, 1'b1, 16'hFFFF, 1'b0, '0);
    send_op(3'd4, 1'b1, 16'hFFFF, 1'b0, '0);
    bus.in_valid = 1'b1;
    bus.flush = 1'b1;
    #1;
    check_w("flush_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    check_w("flush_busy", 64'(bus.busy), 64'd0);
    check_w("flush_out_valid", 64'(bus.out_valid), 64'd0);
    drain();

    // MUL wrap and broadcast immediate.
    ta[0] = 32'h0001_0000;
    tbv[0] = 32'h0001_0000;
    send_op(3'd5, 1'b1, 16'h0001, 1'b0, '0);
    @(posedge clk);
    #1;
    check_w("mul_wrap_lane0", 64'(bus.result[0 +: WIDTH]), 64'd0);
    check_w("mul_wrap_flags", 64'(bus.flags), 64'h4);
    drain();
    for (int l = 0; l < LANES; l++) ta[l] = 32'd7;
    send_op(3'd5, 1'b1, 16'hFFFF, 1'b1, 32'd2);
    @(posedge clk);
    #1;
    for (int l = 0; l < LANES; l++)
      check_w("imm_mul_lane", 64'(bus.result[l*WIDTH +: WIDTH]), 64'd14);
    drain();

    // Asynchronous reset while a result is held.
    or_man = 1'b0;
    send_op(3'd0, 1'b0, '0, 1'b0, '0);
    @(posedge clk);
    #1;
    check_w("pre_rst_out_valid", 64'(bus.out_valid), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check_w("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_w("rst_result", 64'(|bus.result), 64'd0);
    check_w("rst_flags", 64'(bus.flags), 64'd0);
    check_w("rst_busy", 64'(bus.busy), 64'd0);
    exp_q.delete();
    for (int l = 0; l < LANES; l++) acc_m[l] = '0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    or_man = 1'b1;
    @(posedge clk);
    #1;
    for (int l = 0; l < LANES; l++) ta[l] = 32'd1;
    send_op(3'd7, 1'b1, 16'hFFFF, 1'b0, '0);
    @(posedge clk);
    #1;
    check_w("acc_after_rst", 64'(bus.result[15*WIDTH +: WIDTH]), 64'd1);
    drain();

    // Randomized ops with random consumer stalls.
    rand_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      for (int l = 0; l < LANES; l++) begin
        ta[l] = ($urandom_range(0, 7) == 0) ? 32'h7FFF_FFFF : $urandom();
        tbv[l] = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom();
      end
      send_op(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 16'($urandom()),
              ($urandom_range(0, 3) == 0), $urandom());
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rand_en = 1'b0;
    drain();
    check_w("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
